// File: rtl/picomem_pkg.sv
// Shared constants, FSM state type and address-region decode for the picomem controller.
package picomem_pkg;

  localparam logic [31:0] CON_DATA_ADDR = 32'h1000_0000;
  localparam logic [31:0] CON_STAT_ADDR = 32'h1000_0004;
  localparam logic [31:0] PASS_ADDR     = 32'h2000_0000;
  localparam logic [31:0] PASS_MAGIC    = 32'd123456789;
  localparam logic [31:0] ERR_RDATA     = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  typedef enum logic [2:0] {
    RegSram,
    RegConData,
    RegConStat,
    RegPass,
    RegUnmapped
  } region_e;

  // Byte-address decode; the two low address bits never select a device.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] sram_bytes);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    if (waddr == CON_DATA_ADDR)      return RegConData;
    else if (waddr == CON_STAT_ADDR) return RegConStat;
    else if (waddr == PASS_ADDR)     return RegPass;
    else if (addr < sram_bytes)      return RegSram;
    else                             return RegUnmapped;
  endfunction

endpackage

// File: rtl/picomem_sram_ctrl_if.sv
// Picorv32 native memory bus: the core is the master, the controller is the slave.
interface picomem_sram_ctrl_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/picomem_byte_fifo.sv
// Byte FIFO for the console: push side with full/count, valid/ready pop side.
module picomem_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic [7:0]      push_data,
  output logic            full,
  output logic [CntW-1:0] count,
  output logic            pop_valid,
  input  logic            pop_ready,
  output logic [7:0]      pop_data
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [7:0]      mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push;
  logic            do_pop;

  // Status and handshake decode; a pop frees the slot a same-cycle push needs.
  always_comb begin
    full      = (count_q == CntW'(DEPTH));
    count     = count_q;
    pop_valid = (count_q != '0);
    pop_data  = mem[rd_ptr_q];
    do_pop    = pop_valid && pop_ready;
    do_push   = push && (!full || do_pop);
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (do_push && !reset) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/picomem_sram_ctrl.sv
// Memory-side slave for the Picorv32 native bus: SRAM with wait states, console FIFO,
// sticky pass flag and sticky bus-error flag.
module picomem_sram_ctrl
  import picomem_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 32768,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                clock,
  input  logic                reset,
  picomem_sram_ctrl_if.slave  bus,
  output logic                con_valid,
  input  logic                con_ready,
  output logic [7:0]          con_data,
  output logic                tests_passed,
  output logic                bus_err
);

  localparam int unsigned AW   = $clog2(MEM_WORDS);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [3:0] WaitInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [31:0] sram [MEM_WORDS];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic [3:0]  wstrb_q;
  logic        tests_passed_q, bus_err_q;

  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  region_e     region;
  logic        is_write, con_push_req, push_ok, fire, capture;
  logic [AW-1:0] sram_idx;

  logic            fifo_full, fifo_valid, fifo_pop;
  logic [CntW-1:0] fifo_count;
  logic [7:0]      fifo_data, cnt8;

  picomem_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fire && con_push_req),
    .push_data(req_wdata[7:0]),
    .full     (fifo_full),
    .count    (fifo_count),
    .pop_valid(fifo_valid),
    .pop_ready(con_ready),
    .pop_data (fifo_data)
  );

  // In IDLE the request comes straight off the bus; afterwards from the capture registers.
  always_comb begin
    if (state_q == StIdle) begin
      req_addr  = bus.mem_addr;
      req_wdata = bus.mem_wdata;
      req_wstrb = bus.mem_wstrb;
    end else begin
      req_addr  = addr_q;
      req_wdata = wdata_q;
      req_wstrb = wstrb_q;
    end
    region       = decode_region(req_addr, MEM_WORDS * 4);
    is_write     = |req_wstrb;
    sram_idx     = req_addr[AW+1:2];
    con_push_req = is_write && (region == RegConData);
    fifo_pop     = fifo_valid && con_ready;
    push_ok      = !fifo_full || fifo_pop;
    cnt8         = 8'(fifo_count);
  end

  // Next state; fire marks the edge entering RESP, where side effects and rdata land.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.mem_valid) begin
          capture = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end else if (con_push_req && !push_ok) begin
            // Zero-wait console write into a full FIFO parks in WAIT until space appears.
            state_d = StWait;
            cnt_d   = 4'd0;
          end else begin
            state_d = StResp;
            fire    = 1'b1;
          end
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (!(con_push_req && !push_ok)) begin
          state_d = StResp;
          fire    = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Read-data mux for the current request; writes return zero.
  always_comb begin
    rdata_d = '0;
    if (!is_write) begin
      unique case (region)
        RegSram:    rdata_d = sram[sram_idx];
        RegConData: rdata_d = '0;
        RegConStat: rdata_d = {16'h0, cnt8, 7'h0, fifo_full};
        RegPass:    rdata_d = {31'h0, tests_passed_q};
        default:    rdata_d = ERR_RDATA;
      endcase
    end
  end

  // FSM, response data and sticky flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      rdata_q        <= '0;
      tests_passed_q <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fire) begin
        rdata_q <= rdata_d;
        if (is_write && region == RegPass) tests_passed_q <= (req_wdata == PASS_MAGIC);
        if (region == RegUnmapped)         bus_err_q      <= 1'b1;
      end
    end
  end

  // Request capture; no reset needed since IDLE never looks at these.
  always_ff @(posedge clock) begin
    if (capture) begin
      addr_q  <= bus.mem_addr;
      wdata_q <= bus.mem_wdata;
      wstrb_q <= bus.mem_wstrb;
    end
  end

  // SRAM byte-lane write, committed once in the RESP cycle; reset suppresses it.
  always_ff @(posedge clock) begin
    if (!reset && state_q == StResp && region == RegSram) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) sram[sram_idx][i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
    end
  end

  // Output drive.
  always_comb begin
    bus.mem_ready = (state_q == StResp);
    bus.mem_rdata = rdata_q;
    con_valid     = fifo_valid;
    con_data      = fifo_data;
    tests_passed  = tests_passed_q;
    bus_err       = bus_err_q;
  end

endmodule

// File: tb/tb_picomem_sram_ctrl.sv
// Bench for picomem_sram_ctrl: three instances (0, 3 and 5 wait states) share the driven
// request; mem_valid is steered to the selected instance and outputs are muxed back.
module tb_picomem_sram_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        v;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        con_ready;
  int          sel;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [7:0]  con_exp [$];

  picomem_sram_ctrl_if if0 ();
  picomem_sram_ctrl_if if1 ();
  picomem_sram_ctrl_if if2 ();

  logic       cv0, cv1, cv2, tp0, tp1, tp2, be0, be1, be2;
  logic [7:0] cd0, cd1, cd2;

  logic        cur_ready, cur_con_valid, cur_pass, cur_err;
  logic [31:0] cur_rdata;
  logic [7:0]  cur_con_data;

  always #5 clock = ~clock;

  assign if0.mem_valid = v && (sel == 0);
  assign if1.mem_valid = v && (sel == 1);
  assign if2.mem_valid = v && (sel == 2);
  assign if0.mem_addr = addr;  assign if1.mem_addr = addr;  assign if2.mem_addr = addr;
  assign if0.mem_wdata = wdata; assign if1.mem_wdata = wdata; assign if2.mem_wdata = wdata;
  assign if0.mem_wstrb = wstrb; assign if1.mem_wstrb = wstrb; assign if2.mem_wstrb = wstrb;

  picomem_sram_ctrl #(.MEM_WORDS(1024), .WAIT_CYCLES(0), .FIFO_DEPTH(16)) dut0 (
    .clock(clock), .reset(reset), .bus(if0), .con_valid(cv0), .con_ready(con_ready),
    .con_data(cd0), .tests_passed(tp0), .bus_err(be0));
  picomem_sram_ctrl #(.MEM_WORDS(1024), .WAIT_CYCLES(3), .FIFO_DEPTH(16)) dut1 (
    .clock(clock), .reset(reset), .bus(if1), .con_valid(cv1), .con_ready(con_ready),
    .con_data(cd1), .tests_passed(tp1), .bus_err(be1));
  picomem_sram_ctrl #(.MEM_WORDS(1024), .WAIT_CYCLES(5), .FIFO_DEPTH(16)) dut2 (
    .clock(clock), .reset(reset), .bus(if2), .con_valid(cv2), .con_ready(con_ready),
    .con_data(cd2), .tests_passed(tp2), .bus_err(be2));

  always_comb begin
    case (sel)
      0: begin
        cur_ready = if0.mem_ready; cur_rdata = if0.mem_rdata; cur_con_valid = cv0;
        cur_con_data = cd0; cur_pass = tp0; cur_err = be0;
      end
      1: begin
        cur_ready = if1.mem_ready; cur_rdata = if1.mem_rdata; cur_con_valid = cv1;
        cur_con_data = cd1; cur_pass = tp1; cur_err = be1;
      end
      default: begin
        cur_ready = if2.mem_ready; cur_rdata = if2.mem_rdata; cur_con_valid = cv2;
        cur_con_data = cd2; cur_pass = tp2; cur_err = be2;
      end
    endcase
  end

  // One bus transaction on the selected instance; called and returns just after a posedge.
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input logic [31:0] exp, input int exp_lat, input string name);
    int lat;
    bit got;
    logic [31:0] e;
    exp_q.push_back(exp);
    addr = a; wdata = wd; wstrb = ws; v = 1'b1;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (cur_ready === 1'b1) got = 1'b1;
    end
    v = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: mem_ready not seen, got none in %0d cycles, required one", name, lat);
    end else begin
      if (ws == 4'h0) begin
        checks++;
        if (cur_rdata !== e) begin
          errors++;
          $display("FAIL %s rdata: got %h, required %h", name, cur_rdata, e);
        end
      end
      if (exp_lat > 0) begin
        checks++;
        if (lat !== exp_lat) begin
          errors++;
          $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
        end
      end
    end
    @(posedge clock); #1;
    checks++;
    if (cur_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse width: mem_ready got %b one cycle later, required 0", name,
               cur_ready);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      sel = i; #1;
      checks += 5;
      if (cur_ready !== 1'b0) begin errors++; $display("FAIL reset ready[%0d]: got %b, required 0", i, cur_ready); end
      if (cur_rdata !== 32'h0) begin errors++; $display("FAIL reset rdata[%0d]: got %h, required 0", i, cur_rdata); end
      if (cur_con_valid !== 1'b0) begin errors++; $display("FAIL reset con_valid[%0d]: got %b, required 0", i, cur_con_valid); end
      if (cur_pass !== 1'b0) begin errors++; $display("FAIL reset tests_passed[%0d]: got %b, required 0", i, cur_pass); end
      if (cur_err !== 1'b0) begin errors++; $display("FAIL reset bus_err[%0d]: got %b, required 0", i, cur_err); end
    end
    sel = 0; #1;
  endtask

  task automatic test_sram_basic();
    sel = 0; #1;
    txn(32'h100, 32'hA5A5_A5A5, 4'hF, 32'h0, 1, "w0_write_100");
    txn(32'h100, 32'h0, 4'h0, 32'hA5A5_A5A5, 1, "w0_read_100");
    txn(32'h103, 32'h0, 4'h0, 32'hA5A5_A5A5, 1, "w0_read_low_bits_ignored");
  endtask

  task automatic test_subword();
    sel = 0; #1;
    dut0.sram[128] = 32'h1122_3344;
    txn(32'h200, 32'h0000_BB00, 4'b0010, 32'h0, 1, "sub_write_b1");
    txn(32'h200, 32'h0, 4'h0, 32'h1122_BB44, 1, "sub_read_b1");
    txn(32'h200, 32'hDD00_0000, 4'b1000, 32'h0, 1, "sub_write_b3");
    txn(32'h200, 32'h00EE_00FF, 4'b0101, 32'h0, 1, "sub_write_b0b2");
    txn(32'h200, 32'h0, 4'h0, 32'hDDEE_BBFF, 1, "sub_read_all");
  endtask

  task automatic test_pass_and_unmapped();
    sel = 0; #1;
    txn(32'hFFC, 32'h7766_5544, 4'hF, 32'h0, 1, "last_word_write");
    txn(32'hFFC, 32'h0, 4'h0, 32'h7766_5544, 1, "last_word_read");
    checks++;
    if (cur_err !== 1'b0) begin errors++; $display("FAIL bus_err_before: got %b, required 0", cur_err); end
    txn(32'h2000_0000, 32'd123456789, 4'hF, 32'h0, 1, "pass_write_magic");
    checks++;
    if (cur_pass !== 1'b1) begin errors++; $display("FAIL pass_set: got %b, required 1", cur_pass); end
    txn(32'h2000_0000, 32'h0, 4'h0, 32'h1, 1, "pass_read_1");
    txn(32'h2000_0000, 32'd123456788, 4'hF, 32'h0, 1, "pass_write_near");
    checks++;
    if (cur_pass !== 1'b0) begin errors++; $display("FAIL pass_near_clear: got %b, required 0", cur_pass); end
    txn(32'h2000_0000, 32'd123456789, 4'hF, 32'h0, 1, "pass_write_magic2");
    txn(32'h2000_0000, 32'h0, 4'hF, 32'h0, 1, "pass_write_zero");
    checks++;
    if (cur_pass !== 1'b0) begin errors++; $display("FAIL pass_clear: got %b, required 0", cur_pass); end
    txn(32'h2000_0000, 32'h0, 4'h0, 32'h0, 1, "pass_read_0");
    checks++;
    if (cur_err !== 1'b0) begin errors++; $display("FAIL bus_err_mapped: got %b, required 0", cur_err); end
    txn(32'h1000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1, "sram_end_unmapped");
    checks++;
    if (cur_err !== 1'b1) begin errors++; $display("FAIL bus_err_set: got %b, required 1", cur_err); end
    txn(32'h3000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1, "unmapped_read");
    txn(32'h1000_0006, 32'h0, 4'h0, 32'h0, 1, "con_stat_low_bits");
    txn(32'h1000_0000, 32'h0, 4'h0, 32'h0, 1, "con_data_read");
    checks++;
    if (cur_err !== 1'b1) begin errors++; $display("FAIL bus_err_sticky: got %b, required 1", cur_err); end
  endtask

  task automatic test_console_fifo();
    logic [7:0] e8;
    int n;
    sel = 0; con_ready = 1'b0; #1;
    for (int i = 0; i < 16; i++) begin
      con_exp.push_back(8'(8'h41 + i));
      txn(32'h1000_0000, {24'hABCDEF, 8'(8'h41 + i)}, 4'hF, 32'h0, 1, "con_push");
    end
    txn(32'h1000_0004, 32'h0, 4'h0, 32'h0000_1001, 1, "con_stat_full");
    con_exp.push_back(8'h51);
    addr = 32'h1000_0000; wdata = 32'hABCDEF51; wstrb = 4'hF; v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++;
      if (cur_ready !== 1'b0) begin errors++; $display("FAIL con_stall: mem_ready got %b, required 0", cur_ready); end
    end
    e8 = con_exp.pop_front();
    checks += 2;
    if (cur_con_valid !== 1'b1) begin errors++; $display("FAIL con_valid_full: got %b, required 1", cur_con_valid); end
    if (cur_con_data !== e8) begin errors++; $display("FAIL con_head: got %h, required %h", cur_con_data, e8); end
    con_ready = 1'b1;
    @(posedge clock); #1;
    con_ready = 1'b0;
    v = 1'b0;
    checks++;
    if (cur_ready !== 1'b1) begin errors++; $display("FAIL con_release: mem_ready got %b, required 1", cur_ready); end
    @(posedge clock); #1;
    txn(32'h1000_0004, 32'h0, 4'h0, 32'h0000_1001, 1, "con_stat_refilled");
    con_ready = 1'b1;
    n = 0;
    while (con_exp.size() > 0 && n < 40) begin
      if (cur_con_valid === 1'b1) begin
        e8 = con_exp.pop_front();
        checks++;
        if (cur_con_data !== e8) begin errors++; $display("FAIL con_drain: got %h, required %h", cur_con_data, e8); end
      end
      @(posedge clock); #1;
      n++;
    end
    con_ready = 1'b0;
    checks++;
    if (cur_con_valid !== 1'b0 || con_exp.size() != 0) begin
      errors++;
      $display("FAIL con_empty: con_valid got %b with %0d bytes undrained, required 0 and 0",
               cur_con_valid, con_exp.size());
    end
    txn(32'h1000_0004, 32'h0, 4'h0, 32'h0, 1, "con_stat_empty");
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic [31:0] e;
    sel = 1; #1;
    txn(32'h100, 32'h5A5A_0F0F, 4'hF, 32'h0, 4, "w3_write");
    exp_q.push_back(32'h5A5A_0F0F);
    exp_q.push_back(32'h5A5A_0F0F);
    addr = 32'h100; wdata = 32'h0; wstrb = 4'h0; v = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock); #1;
      if (cur_ready === 1'b1) begin
        pulses++;
        checks++;
        if (i != ((pulses == 1) ? 4 : 9)) begin
          errors++;
          $display("FAIL b2b_position: pulse %0d got at cycle %0d, required %0d", pulses, i,
                   (pulses == 1) ? 4 : 9);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          if (cur_rdata !== e) begin errors++; $display("FAIL b2b_rdata: got %h, required %h", cur_rdata, e); end
        end
      end
    end
    v = 1'b0;
    exp_q.delete();
    checks++;
    if (pulses != 2) begin errors++; $display("FAIL b2b_count: got %0d pulses, required 2", pulses); end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_reset_abort();
    sel = 2; #1;
    txn(32'h300, 32'h1234_5678, 4'hF, 32'h0, 6, "w5_write");
    txn(32'h300, 32'h0, 4'h0, 32'h1234_5678, 6, "w5_read");
    addr = 32'h300; wdata = 32'hCAFE_F00D; wstrb = 4'hF; v = 1'b1;
    repeat (2) begin
      @(posedge clock); #1;
      checks++;
      if (cur_ready !== 1'b0) begin errors++; $display("FAIL abort_wait: mem_ready got %b, required 0", cur_ready); end
    end
    reset = 1'b1; v = 1'b0;
    @(posedge clock); #1;
    checks += 4;
    if (cur_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b, required 0", cur_ready); end
    if (cur_rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h, required 0", cur_rdata); end
    if (cur_con_valid !== 1'b0) begin errors++; $display("FAIL abort_con_valid: got %b, required 0", cur_con_valid); end
    if (cur_err !== 1'b0) begin errors++; $display("FAIL abort_bus_err: got %b, required 0", cur_err); end
    reset = 1'b0;
    repeat (8) begin
      @(posedge clock); #1;
      checks++;
      if (cur_ready !== 1'b0) begin errors++; $display("FAIL abort_no_ready: got %b, required 0", cur_ready); end
    end
    txn(32'h300, 32'h0, 4'h0, 32'h1234_5678, 6, "abort_word_kept");
  endtask

  initial begin
    v = 1'b0; addr = '0; wdata = '0; wstrb = '0; con_ready = 1'b0; sel = 0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    test_reset();
    test_sram_basic();
    test_subword();
    test_pass_and_unmapped();
    test_console_fifo();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
